payload_aligner: RTL and testbench
==================================

Name: payload_aligner

Overview:
- Strips the fixed 6-byte header from an incoming 64-bit packet stream.
- Realigns the payload so payload byte 0 sits in output byte lane 0.
- Presents the three decoded header fields alongside every output payload beat.
- Sits between the packet ingress bus (packet_intf) and downstream payload consumers (payload_aligner_intf).

Parameters:
- packet_width_bits, 64, data bus width (packet_pkg constant).
- packet_width_bytes, 8, packet_width_bits/8.
- byte_enable_width_bits, 4, width of the valid-byte count (values 0..8).
- header_bytes, 6, total header length on the sop beat.
- out_fifo_depth, 4, output buffer entries.

Ports:
- iClk  in  1  sole clock, rising edge.
- iReset  in  1  asynchronous, active-low reset.
- iValid  in  1  input beat valid.
- iPacket  in  64  input beat; byte 0 in bits [63:56], byte 7 in [7:0].
- iSop  in  1  first beat of packet (qualified by iValid).
- iEop  in  1  last beat of packet (qualified by iValid).
- iByte_enable  in  4  on eop beat, count of valid leading bytes (1..8); ignored otherwise.
- oPayload  out  64  aligned payload, byte 0 in [63:56].
- oPayload_valid  out  1  output beat valid.
- oHeaders  out  48  headers_t {header_a, header_b, header_c} of the current packet.
- oSop  out  1  first output beat of packet.
- oEop  out  1  last output beat of packet.
- oByte_enable  out  4  count of valid leading payload bytes on the eop beat (0..8); 8 on non-eop beats.

Behaviour:
- No backpressure; the downstream always accepts.
- Sop beat layout: bytes 0-1 header_a, 2-3 header_b, 4-5 header_c, 6-7 payload bytes 0-1.
- Following beats carry 8 payload bytes each.
- Headers are latched on the sop beat. oHeaders holds that value on every output beat of the packet.
- A 2-byte carry register holds input bytes 6-7 of each accepted beat.
- Each non-sop input beat forms one aligned beat: carry bytes occupy lanes 0-1, input bytes 0-5 occupy lanes 2-7.
- A sop beat without eop produces no output; it only fills the carry.
- Eop handling, with n = iByte_enable and c = 2 carried bytes (c = n-6 on a sop+eop beat):
  - Sop+eop beat: emit one beat with sop=eop=1 and oByte_enable = n-6 (0..2). n=6 gives a zero-length payload beat with oByte_enable=0 and oPayload_valid=1.
  - Non-sop eop with n ≤ 6: emit one beat, eop=1, oByte_enable = n+2.
  - Non-sop eop with n = 7..8: emit a full beat (oByte_enable=8, eop=0), then a flush beat with eop=1 and oByte_enable = n-6, holding the remaining carry bytes in lanes 0-1.
- oSop is set on the first emitted beat of each packet.
- Invalid lanes of oPayload are driven to 0.
- Aligned beats are written to a 4-entry output FIFO. Up to 2 writes per cycle (current beat plus flush); 1 read per cycle. The head drives the outputs.
- Latency: input beat sampled at edge t appears at the outputs after edge t+1. A flush beat follows one cycle later.
- Back-to-back packets (zero gap, including flush overlapping the next sop) must never drop or reorder beats.
- iValid low mid-packet: the carry and state hold, and no output is generated.
- A beat without iSop outside a packet is dropped.
- iSop while a packet is open aborts the old packet: its carry is discarded with no eop emitted, and the new packet starts.
- Reset (async, iReset=0): FIFO empty, carry and state cleared. All outputs 0: oPayload_valid, oSop, oEop, oPayload, oHeaders, and oByte_enable.
- Reset asserted mid-packet discards all in-flight data.

Decomposition:
- payload_aligner_pkg holds headers_t (packed struct of three 16-bit fields), the width constants, and the header_bytes constant.
- packet_pkg already holds packet_width_bits.
- One natural sub-module: aligner_out_fifo, 4 entries of {payload, headers, sop, eop, byte_enable} with dual write / single read.

Test Plan:
1. Single beat, iSop=iEop=1, iByte_enable=8, iPacket=0x1111_2222_3333_AABB -> one beat: sop=eop=1, headers {1111,2222,3333}, oByte_enable=2, oPayload=0xAABB_0000_0000_0000.
2. Single beat, iByte_enable=6 -> one beat: sop=eop=1, oByte_enable=0, headers correct.
3. Beat0 full, beat1 iByte_enable=4 with bytes 0x01..0x04 -> one beat: sop=eop=1, oByte_enable=6, payload = carry 2 bytes then 01 02 03 04.
4. Beat0 full, beat1 iByte_enable=8 -> two consecutive beats: first sop=1, eop=0, be=8; second eop=1, be=2 containing input bytes 6-7.
5. Test-4 packet followed with zero gap by a test-1 packet -> three beats in order with correct headers per packet, none lost.
6. Random sequence of 1000 packets with random lengths and 0-5 cycle gaps -> outputs match a reference model. Separately, reset asserted mid-packet -> outputs zero and the next packet is clean.

Source files
------------

// File: rtl/packet_pkg.sv
// Shared packet-bus constants for the ingress side.
package packet_pkg;
  localparam int packet_width_bits = 64;
endpackage

// File: rtl/payload_aligner_pkg.sv
// Types and constants shared by the payload aligner and its output buffer.
package payload_aligner_pkg;
  localparam int packet_width_bits = packet_pkg::packet_width_bits;
  localparam int packet_width_bytes = packet_width_bits / 8;
  localparam int byte_enable_width_bits = 4;
  localparam int header_bytes = 6;
  localparam int out_fifo_depth = 4;

  localparam logic [byte_enable_width_bits-1:0] be_full =
    byte_enable_width_bits'(packet_width_bytes);
  localparam logic [byte_enable_width_bits-1:0] be_hdr =
    byte_enable_width_bits'(header_bytes);
  localparam logic [byte_enable_width_bits-1:0] be_carry =
    byte_enable_width_bits'(packet_width_bytes - header_bytes);

  typedef struct packed {
    logic [15:0] header_a;
    logic [15:0] header_b;
    logic [15:0] header_c;
  } headers_t;

  typedef struct packed {
    logic [packet_width_bits-1:0] payload;
    headers_t headers;
    logic sop;
    logic eop;
    logic [byte_enable_width_bits-1:0] be;
  } beat_t;

  // Keeps the n leading bytes (byte 0 in the MSBs); n=8 keeps all.
  function automatic logic [packet_width_bits-1:0] lead_mask(
    input logic [byte_enable_width_bits-1:0] n
  );
    logic [packet_width_bits-1:0] ones;
    ones = '1;
    lead_mask = ~(ones >> {n, 3'b000});
  endfunction
endpackage

// File: rtl/payload_aligner_out_fifo.sv
// Output beat buffer: up to two writes and exactly one read per cycle.
// The head is read whenever the buffer is non-empty.
module aligner_out_fifo
  import payload_aligner_pkg::*;
(
  input  logic  iClk,
  input  logic  iReset,
  input  logic  i_wr0,
  input  logic  i_wr1,
  input  beat_t i_beat0,
  input  beat_t i_beat1,
  output logic  o_valid,
  output beat_t o_head
);
  localparam int AW = $clog2(out_fifo_depth);

  beat_t r_mem [out_fifo_depth];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0] r_count;
  logic [AW:0] w_nwr;
  logic w_rd;

  assign w_rd = (r_count != '0);
  assign w_nwr = (AW+1)'(i_wr0) + (AW+1)'(i_wr1);
  assign o_valid = w_rd;
  assign o_head = r_mem[r_rptr];

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      for (int i = 0; i < out_fifo_depth; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_wr0) r_mem[r_wptr] <= i_beat0;
      if (i_wr1) r_mem[r_wptr + AW'(1)] <= i_beat1;
      r_wptr <= r_wptr + w_nwr[AW-1:0];
      r_rptr <= r_rptr + AW'(w_rd);
      r_count <= r_count + w_nwr - (AW+1)'(w_rd);
    end
  end
endmodule

// File: rtl/payload_aligner.sv
// Strips the 6-byte header from a 64-bit packet stream and realigns
// the payload to lane 0, tagging every beat with the packet headers.
module payload_aligner
  import payload_aligner_pkg::*;
(
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iValid,
  input  logic [63:0] iPacket,
  input  logic        iSop,
  input  logic        iEop,
  input  logic [3:0]  iByte_enable,
  output logic [63:0] oPayload,
  output logic        oPayload_valid,
  output logic [47:0] oHeaders,
  output logic        oSop,
  output logic        oEop,
  output logic [3:0]  oByte_enable
);
  logic r_s_valid;
  logic [packet_width_bits-1:0] r_s_pkt;
  logic r_s_sop;
  logic r_s_eop;
  logic [3:0] r_s_be;

  logic r_open;
  logic r_first;
  logic [15:0] r_carry;
  headers_t r_hdr;

  logic w_open_nx;
  logic w_first_nx;
  logic [15:0] w_carry_nx;
  headers_t w_hdr_nx;

  logic [packet_width_bits-1:0] w_aligned;
  logic [packet_width_bits-1:0] w_tail;
  headers_t w_sop_hdr;
  logic [3:0] w_sop_be;
  logic [3:0] w_last_be;
  logic [3:0] w_flush_be;
  logic w_short;
  logic w_take_sop;
  logic w_take_mid;

  logic w_wr0;
  logic w_wr1;
  beat_t w_beat0;
  beat_t w_beat1;
  logic w_head_valid;
  beat_t w_head;

  // Input stage register gives the one-cycle ingress latency.
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      r_s_valid <= 1'b0;
      r_s_pkt <= '0;
      r_s_sop <= 1'b0;
      r_s_eop <= 1'b0;
      r_s_be <= '0;
    end else begin
      r_s_valid <= iValid;
      r_s_pkt <= iPacket;
      r_s_sop <= iSop;
      r_s_eop <= iEop;
      r_s_be <= (iByte_enable > be_full) ? be_full : iByte_enable;
    end
  end

  assign w_aligned = {r_carry, r_s_pkt[63:16]};
  assign w_tail = {r_s_pkt[15:0], 48'h0};
  assign w_sop_hdr = r_s_pkt[63:16];
  assign w_sop_be = (r_s_be > be_hdr) ? r_s_be - be_hdr : '0;
  assign w_flush_be = r_s_be - be_hdr;
  assign w_last_be = r_s_be + be_carry;
  assign w_short = (r_s_be <= be_hdr);
  // A sop always wins, which also aborts any open packet.
  assign w_take_sop = r_s_valid & r_s_sop;
  assign w_take_mid = r_s_valid & ~r_s_sop & r_open;

  always_comb begin
    w_open_nx = r_open;
    w_first_nx = r_first;
    w_carry_nx = r_carry;
    w_hdr_nx = r_hdr;
    w_wr0 = 1'b0;
    w_wr1 = 1'b0;
    w_beat0 = '0;
    w_beat1 = '0;
    unique case (1'b1)
      w_take_sop: begin
        w_hdr_nx = w_sop_hdr;
        w_carry_nx = r_s_pkt[15:0];
        w_open_nx = ~r_s_eop;
        w_first_nx = ~r_s_eop;
        if (r_s_eop) begin
          w_wr0 = 1'b1;
          w_beat0.payload = w_tail & lead_mask(w_sop_be);
          w_beat0.headers = w_sop_hdr;
          w_beat0.sop = 1'b1;
          w_beat0.eop = 1'b1;
          w_beat0.be = w_sop_be;
        end
      end
      w_take_mid: begin
        w_carry_nx = r_s_pkt[15:0];
        w_first_nx = 1'b0;
        w_open_nx = ~r_s_eop;
        w_wr0 = 1'b1;
        w_beat0.payload = w_aligned;
        w_beat0.headers = r_hdr;
        w_beat0.sop = r_first;
        w_beat0.be = be_full;
        if (r_s_eop && w_short) begin
          w_beat0.eop = 1'b1;
          w_beat0.be = w_last_be;
          w_beat0.payload = w_aligned & lead_mask(w_last_be);
        end
        if (r_s_eop && !w_short) begin
          w_wr1 = 1'b1;
          w_beat1.payload = w_tail & lead_mask(w_flush_be);
          w_beat1.headers = r_hdr;
          w_beat1.eop = 1'b1;
          w_beat1.be = w_flush_be;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      r_open <= 1'b0;
      r_first <= 1'b0;
      r_carry <= '0;
      r_hdr <= '0;
    end else begin
      r_open <= w_open_nx;
      r_first <= w_first_nx;
      r_carry <= w_carry_nx;
      r_hdr <= w_hdr_nx;
    end
  end

  aligner_out_fifo u_fifo (
    .iClk    (iClk),
    .iReset  (iReset),
    .i_wr0   (w_wr0),
    .i_wr1   (w_wr1),
    .i_beat0 (w_beat0),
    .i_beat1 (w_beat1),
    .o_valid (w_head_valid),
    .o_head  (w_head)
  );

  assign oPayload_valid = w_head_valid;
  assign oPayload = w_head_valid ? w_head.payload : '0;
  assign oHeaders = w_head_valid ? w_head.headers : '0;
  assign oSop = w_head_valid & w_head.sop;
  assign oEop = w_head_valid & w_head.eop;
  assign oByte_enable = w_head_valid ? w_head.be : '0;
endmodule

// File: tb/tb_payload_aligner.sv
// Directed and randomized checks of the payload aligner against
// hand-computed beats and a byte-level packet model.
module tb_payload_aligner;
  logic iClk = 1'b0;
  logic iReset = 1'b0;
  logic iValid = 1'b0;
  logic [63:0] iPacket = '0;
  logic iSop = 1'b0;
  logic iEop = 1'b0;
  logic [3:0] iByte_enable = '0;
  logic [63:0] oPayload;
  logic oPayload_valid;
  logic [47:0] oHeaders;
  logic oSop;
  logic oEop;
  logic [3:0] oByte_enable;

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] q_exp[$];

  payload_aligner dut (
    .iClk           (iClk),
    .iReset         (iReset),
    .iValid         (iValid),
    .iPacket        (iPacket),
    .iSop           (iSop),
    .iEop           (iEop),
    .iByte_enable   (iByte_enable),
    .oPayload       (oPayload),
    .oPayload_valid (oPayload_valid),
    .oHeaders       (oHeaders),
    .oSop           (oSop),
    .oEop           (oEop),
    .oByte_enable   (oByte_enable)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] obs();
    return {9'b0, oPayload_valid, oPayload, oHeaders,
            oSop, oEop, oByte_enable};
  endfunction

  function automatic logic [127:0] mk(input logic [63:0] p,
    input logic [47:0] h, input logic s, input logic e,
    input logic [3:0] be);
    return {9'b0, 1'b1, p, h, s, e, be};
  endfunction

  always @(negedge iClk) begin
    if (iReset && oPayload_valid) begin
      if (q_exp.size() == 0) chk("extra_beat", obs(), '0);
      else chk("beat", obs(), q_exp.pop_front());
    end
  end

  task automatic drive(input logic [63:0] p, input logic s,
                       input logic e, input logic [3:0] be);
    @(negedge iClk);
    iValid = 1'b1;
    iPacket = p;
    iSop = s;
    iEop = e;
    iByte_enable = be;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge iClk);
      iValid = 1'b0;
      iPacket = '0;
      iSop = 1'b0;
      iEop = 1'b0;
      iByte_enable = '0;
    end
  endtask

  task automatic drain(input string tag);
    idle(6);
    chk(tag, 128'(q_exp.size()), '0);
  endtask

  task automatic pkt_t1();
    q_exp.push_back(mk(64'hAABB_0000_0000_0000, 48'h1111_2222_3333,
                       1, 1, 4'd2));
    drive(64'h1111_2222_3333_AABB, 1, 1, 4'd8);
  endtask

  task automatic pkt_t4();
    q_exp.push_back(mk(64'h0A0B_1011_1213_1415, 48'h1234_5678_9ABC,
                       1, 0, 4'd8));
    q_exp.push_back(mk(64'h1617_0000_0000_0000, 48'h1234_5678_9ABC,
                       0, 1, 4'd2));
    drive(64'h1234_5678_9ABC_0A0B, 1, 0, 4'd8);
    drive(64'h1011_1213_1415_1617, 0, 1, 4'd8);
  endtask

  task automatic pkt_t3(input int gap);
    q_exp.push_back(mk(64'hD4E5_0102_0304_0000, 48'hA1A1_B2B2_C3C3,
                       1, 1, 4'd6));
    drive(64'hA1A1_B2B2_C3C3_D4E5, 1, 0, 4'd3);
    if (gap > 0) idle(gap);
    drive(64'h0102_0304_FFFF_FFFF, 0, 1, 4'd4);
  endtask

  task automatic rand_pkt();
    int len;
    int tot;
    int k;
    int cnt;
    byte unsigned b[$];
    logic [47:0] h;
    logic [63:0] p;
    logic [3:0] be;
    len = $urandom_range(0, 40);
    tot = 6 + len;
    h = {16'($urandom), 32'($urandom)};
    for (int i = 0; i < 6; i++) b.push_back(h[47-8*i -: 8]);
    for (int i = 0; i < len; i++) b.push_back(8'($urandom));
    if (len == 0) q_exp.push_back(mk('0, h, 1, 1, 4'd0));
    for (int j = 0; j * 8 < len; j++) begin
      p = '0;
      cnt = (len - 8 * j > 8) ? 8 : len - 8 * j;
      for (int i = 0; i < cnt; i++) p[63-8*i -: 8] = b[6+8*j+i];
      q_exp.push_back(mk(p, h, j == 0, (j + 1) * 8 >= len, 4'(cnt)));
    end
    k = (tot + 7) / 8;
    for (int bt = 0; bt < k; bt++) begin
      p = {$urandom, $urandom};
      for (int i = 0; i < 8; i++)
        if (8 * bt + i < tot) p[63-8*i -: 8] = b[8*bt+i];
      be = (bt == k - 1) ? 4'(tot - 8 * bt) : 4'($urandom);
      drive(p, bt == 0, bt == k - 1, be);
      if (bt != k - 1 && $urandom_range(0, 3) == 0)
        idle($urandom_range(1, 2));
    end
    idle($urandom_range(0, 5));
  endtask

  initial begin
    repeat (2) @(negedge iClk);
    chk("reset_outs", obs(), '0);
    iReset = 1'b1;
    idle(2);

    pkt_t1();
    idle(1);
    chk("lat_early", 128'(oPayload_valid), 128'(0));
    @(negedge iClk);
    chk("lat_t1", 128'(oPayload_valid), 128'(1));
    drain("t1_drain");

    q_exp.push_back(mk('0, 48'h1111_2222_3333, 1, 1, 4'd0));
    drive(64'h1111_2222_3333_CCDD, 1, 1, 4'd6);
    drain("t2_drain");

    pkt_t3(0);
    drain("t3_drain");

    pkt_t4();
    drain("t4_drain");

    pkt_t4();
    pkt_t1();
    drain("t5_drain");

    pkt_t3(3);
    drain("gap_drain");

    q_exp.push_back(mk(64'h5555_6666_7777_8888, 48'h0001_0002_0003,
                       1, 0, 4'd8));
    drive(64'h0001_0002_0003_5555, 1, 0, 4'd8);
    drive(64'h6666_7777_8888_9999, 0, 0, 4'd8);
    pkt_t1();
    drain("abort_drain");

    drive(64'hDEAD_BEEF_0123_4567, 0, 1, 4'd8);
    pkt_t1();
    drain("drop_drain");

    q_exp.push_back(mk(64'h0102_0304_0506_0708, 48'hAAAA_BBBB_CCCC,
                       1, 0, 4'd8));
    drive(64'hAAAA_BBBB_CCCC_0102, 1, 0, 4'd8);
    drive(64'h0304_0506_0708_090A, 0, 0, 4'd8);
    drive(64'h0B0C_0D0E_0F10_1112, 0, 1, 4'd8);
    @(negedge iClk);
    iReset = 1'b0;
    iValid = 1'b0;
    iSop = 1'b0;
    iEop = 1'b0;
    #1;
    chk("rst_mid", obs(), '0);
    q_exp.delete();
    repeat (2) @(negedge iClk);
    iReset = 1'b1;
    idle(4);
    drive(64'h0B0C_0D0E_0F10_1112, 0, 1, 4'd8);
    pkt_t1();
    drain("rst_drain");

    for (int n = 0; n < 1000; n++) rand_pkt();
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
